// File: rtl/ifetch_unit_if.sv
// Dispatch-side bundle of the instruction fetch front end.
// Latency: none, wires only.
// Backpressure: dispatch pops with Rd_en; Empty tells it when nothing is ready.
interface ifetch_unit_if;
    logic        Rd_en;
    logic [31:0] Jmp_branch_address;
    logic        Jmp_branch_valid;
    logic [31:0] Pc_out;
    logic [31:0] Inst;
    logic        Empty;

    // Dispatch stage drives pops and redirects, consumes instructions.
    modport master (
        output Rd_en,
        output Jmp_branch_address,
        output Jmp_branch_valid,
        input  Pc_out,
        input  Inst,
        input  Empty
    );

    // Fetch unit side.
    modport slave (
        input  Rd_en,
        input  Jmp_branch_address,
        input  Jmp_branch_valid,
        output Pc_out,
        output Inst,
        output Empty
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: line ROM cache feeding a DEPTH-line queue, one 32-bit word out per pop.
// Latency: line request -> queue write in 2 edges; redirect -> Empty=0 two edges after the strobe.
// Backpressure: requests stop while queued + in-flight lines reach DEPTH; pops ignored when Empty.
module ifetch_unit #(
    parameter int DEPTH       = 4,
    parameter int CACHE_LINES = 256
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(CACHE_LINES);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    // Cache <-> queue nets
    logic [31:0]  Pc_in;
    logic         Rd_en_cache;
    logic [127:0] Dout;
    logic         Dout_valid;

    // Queue state
    logic [127:0]     q_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       offset;
    logic [31:0]      pc_out_q;
    logic             inflight;
    logic             drop;

    logic             jmp;
    logic             pop;
    logic             deq;
    logic             wr;
    logic [CNT_W:0]   pending;
    logic [IDX_W-1:0] cache_idx;
    logic [127:0]     rom_dat;
    logic [127:0]     head_line;
    logic [31:0]      inst_w;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + PTR_W'(1);
    endfunction

    assign cache_idx = Pc_in[IDX_W+3:4];

    // Line i holds byte addresses i*16 .. i*16+12, word 0 lowest
    logic [31:0] line_base;
    assign line_base = 32'(cache_idx) << 4;
    assign rom_dat   = {line_base + 32'd12, line_base + 32'd8,
                        line_base + 32'd4,  line_base};

    // Cache read port: one-cycle registered line, Dout holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            Dout_valid <= 1'b0;
        end else if (Rd_en_cache) begin
            Dout       <= rom_dat;
            Dout_valid <= 1'b1;
        end else begin
            Dout_valid <= 1'b0;
        end
    end

    // The line already in flight counts against capacity so the queue never overflows
    assign pending     = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign Rd_en_cache = !reset && (pending < DEPTH_C);

    assign jmp = bus.Jmp_branch_valid;
    assign pop = bus.Rd_en && (count != '0) && !jmp;
    assign deq = pop && (offset == 2'd3);
    // Response to a request issued on the redirect edge belongs to the old stream
    assign wr  = Dout_valid && !drop && !jmp;

    // Queue control: redirect beats pop and write; pop+dequeue with write nets to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            Pc_in    <= '0;
            pc_out_q <= '0;
            count    <= '0;
            offset   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else if (jmp) begin
            Pc_in    <= {bus.Jmp_branch_address[31:4], 4'b0};
            pc_out_q <= bus.Jmp_branch_address;
            offset   <= bus.Jmp_branch_address[3:2];
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            drop     <= 1'b1;
        end else begin
            drop     <= 1'b0;
            inflight <= Rd_en_cache;
            if (Rd_en_cache) begin
                Pc_in <= Pc_in + 32'd16;
            end
            if (wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                offset   <= offset + 2'd1;
                pc_out_q <= pc_out_q + 32'd4;
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Line storage, no reset needed: count gates visibility
    always_ff @(posedge clk) begin
        if (!reset && wr) begin
            q_mem[wr_ptr] <= Dout;
        end
    end

    // Head word select
    always_comb begin
        head_line = q_mem[rd_ptr];
        inst_w    = head_line[31:0];
        case (offset)
            2'd0:    inst_w = head_line[31:0];
            2'd1:    inst_w = head_line[63:32];
            2'd2:    inst_w = head_line[95:64];
            default: inst_w = head_line[127:96];
        endcase
    end

    assign bus.Inst   = inst_w;
    assign bus.Pc_out = pc_out_q;
    assign bus.Empty  = (count == '0);

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic clk = 1'b0;
    logic reset;

    ifetch_unit_if bus();

    always #5 clk = ~clk;

    ifetch_unit #(.DEPTH(4), .CACHE_LINES(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        rd;
        logic        jv;
        logic [31:0] ja;
        logic        e_empty;
        logic        chk_inst;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic rst, input logic rd, input logic jv, input logic [31:0] ja,
                       input logic e_empty, input logic chk_inst,
                       input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.rd = rd; v.jv = jv; v.ja = ja;
        v.e_empty = e_empty; v.chk_inst = chk_inst; v.e_inst = e_inst; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        reset                  = 1'b1;
        bus.Rd_en              = 1'b0;
        bus.Jmp_branch_valid   = 1'b0;
        bus.Jmp_branch_address = '0;

        // rst rd jv addr           empty chk inst           pc
        add(1, 0, 0, 32'h0,          1, 0, 32'h0,          32'h0);          // 0 reset edge
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,          32'h0);          // 1 first request
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 32'h0,      0, 1, 32'h0,          32'h0);          // 2..6 fill, no pops
        for (int k = 1; k <= 20; k++)
            add(0, 1, 0, 32'h0,      0, 1, 32'(4 * k),     32'(4 * k));     // 7..26 stream
        for (int k = 0; k < 6; k++)
            add(0, 0, 0, 32'h0,      0, 1, 32'h50,         32'h50);         // 27..32 refill
        add(0, 0, 1, 32'h140,        1, 0, 32'h0,          32'h140);        // 33 redirect while full
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,          32'h140);        // 34
        add(0, 0, 0, 32'h0,          0, 1, 32'h140,        32'h140);        // 35
        add(0, 1, 1, 32'h148,        1, 0, 32'h0,          32'h148);        // 36 redirect beats pop
        add(0, 1, 0, 32'h0,          1, 0, 32'h0,          32'h148);        // 37 pop while empty
        add(0, 1, 0, 32'h0,          0, 1, 32'h148,        32'h148);        // 38
        add(0, 1, 0, 32'h0,          0, 1, 32'h14C,        32'h14C);        // 39
        add(0, 1, 0, 32'h0,          0, 1, 32'h150,        32'h150);        // 40 next line
        add(0, 1, 0, 32'h0,          0, 1, 32'h154,        32'h154);        // 41
        add(1, 1, 0, 32'h0,          1, 0, 32'h0,          32'h0);          // 42 mid-stream reset
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,          32'h0);          // 43
        add(0, 0, 0, 32'h0,          0, 1, 32'h0,          32'h0);          // 44
        add(0, 1, 0, 32'h0,          0, 1, 32'h4,          32'h4);          // 45
        add(0, 0, 1, 32'hFFFFFFFC,   1, 0, 32'h0,          32'hFFFFFFFC);   // 46 redirect near top
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,          32'hFFFFFFFC);   // 47
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,          32'hFFFFFFFC);   // 48
        add(0, 1, 0, 32'h0,          0, 1, 32'h0,          32'h0);          // 49 wrap, pop+write
        add(0, 1, 0, 32'h0,          0, 1, 32'h4,          32'h4);          // 50

        for (int i = 0; i < vecs.size(); i++) begin
            reset                  = vecs[i].rst;
            bus.Rd_en              = vecs[i].rd;
            bus.Jmp_branch_valid   = vecs[i].jv;
            bus.Jmp_branch_address = vecs[i].ja;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d empty", i), {31'b0, bus.Empty}, {31'b0, vecs[i].e_empty});
            chk($sformatf("v%0d pc_out", i), bus.Pc_out, vecs[i].e_pc);
            if (vecs[i].chk_inst)
                chk($sformatf("v%0d inst", i), bus.Inst, vecs[i].e_inst);

            // Multi-cycle corner checks on the fetch side
            if (i == 5) begin
                chk("fill pc_in", dut.Pc_in, 32'h40);
                chk("fill rd_en_cache", {31'b0, dut.Rd_en_cache}, 32'h0);
            end
            if (i == 6)
                chk("full pc_in hold", dut.Pc_in, 32'h40);
            if (i == 32)
                chk("refill rd_en_cache", {31'b0, dut.Rd_en_cache}, 32'h0);
            if (i == 42) begin
                chk("rst pc_in", dut.Pc_in, 32'h0);
                chk("rst dout_valid", {31'b0, dut.Dout_valid}, 32'h0);
                chk("rst count", 32'(dut.count), 32'h0);
                chk("rst offset", 32'(dut.offset), 32'h0);
            end
            if (i == 43)
                chk("restart pc_in", dut.Pc_in, 32'h10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
